// File: rtl/cs_pkg.sv
// Shared types and helpers for the carry-save resolver.
package cs_pkg;

  typedef enum logic [1:0] {CS_IDLE, CS_BUSY, CS_DONE} cs_state_e;

  // Number of CHUNK-bit slices needed to cover rw result bits.
  function automatic int cs_nchunk(int rw, int chunk);
    return (rw + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/cs_chunk_add.sv
// CHUNK-bit combinational adder with carry in/out; one slice of the resolver.
module cs_chunk_add #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] s_o,
  output logic             cout_o
);

  assign {cout_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};

endmodule

// File: rtl/cs_resolve_seq.sv
// Sequential carry-save to binary resolver: sum + (carry << 1), CHUNK bits per cycle,
// with the inter-chunk carry held in a register.
// Optional feature macro: CS_RESOLVE_EARLY_EXIT_EN (finish as soon as the remaining
// chunks are known to be zero).
module cs_resolve_seq
  import cs_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_vld,
  output logic               in_rdy,
  input  logic [WIDTH-1:0]   in_sum,
  input  logic [WIDTH-1:0]   in_carry,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [WIDTH+1:0]   out_result
);

  localparam int unsigned RW     = WIDTH + 2;
  localparam int unsigned NCHUNK = unsigned'(cs_nchunk(int'(RW), int'(CHUNK)));
  localparam int unsigned PW     = NCHUNK * CHUNK;
  localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] IdxOne  = IW'(1);
  localparam logic [IW-1:0] IdxLast = IW'(NCHUNK - 1);

  if (CHUNK < 1 || CHUNK > RW) begin : g_bad_chunk
    $error("cs_resolve_seq: CHUNK must be in 1..WIDTH+2");
  end

  cs_state_e                    state_q, state_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic                         cin_q, cin_d;
  logic [NCHUNK-1:0][CHUNK-1:0] a_q, a_d, b_q, b_d;
  logic [RW-1:0]                res_q, res_d;

  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_cout;
  logic             early_exit;

  cs_chunk_add #(
    .CHUNK (CHUNK)
  ) u_chunk_add (
    .a_i    (a_q[idx_q]),
    .b_i    (b_q[idx_q]),
    .cin_i  (cin_q),
    .s_o    (chunk_sum),
    .cout_o (chunk_cout)
  );

`ifdef CS_RESOLVE_EARLY_EXIT_EN
  logic upper_zero;

  // Zero-detect on every operand chunk above the one being resolved.
  always_comb begin
    upper_zero = 1'b1;
    for (int c = 0; c < int'(NCHUNK); c++) begin
      if (c > int'(idx_q) && ((|a_q[c]) || (|b_q[c]))) upper_zero = 1'b0;
    end
  end

  assign early_exit = ~chunk_cout & upper_zero;
`else
  assign early_exit = 1'b0;
`endif

  // Next-state: handshake, chunk write-back, carry ripple and index advance.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cin_d   = cin_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    unique case (state_q)
      CS_IDLE: begin
        if (in_vld) begin
          a_d     = PW'(in_sum);
          b_d     = PW'({in_carry, 1'b0});
          idx_d   = '0;
          cin_d   = 1'b0;
          state_d = CS_BUSY;
        end
      end
      CS_BUSY: begin
        for (int j = 0; j < int'(RW); j++) begin
          if (j / int'(CHUNK) == int'(idx_q)) begin
            res_d[j] = chunk_sum[j % int'(CHUNK)];
          end else if (early_exit && (j / int'(CHUNK) > int'(idx_q))) begin
            // Stale bits from the previous result would otherwise survive.
            res_d[j] = 1'b0;
          end
        end
        cin_d = chunk_cout;
        idx_d = idx_q + IdxOne;
        if (idx_q == IdxLast || early_exit) state_d = CS_DONE;
      end
      CS_DONE: begin
        if (out_rdy) state_d = CS_IDLE;
      end
      default: state_d = CS_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CS_IDLE;
      idx_q   <= '0;
      cin_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cin_q   <= cin_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  assign in_rdy     = (state_q == CS_IDLE);
  assign out_vld    = (state_q == CS_DONE);
  assign out_result = res_q;

endmodule
